// File: rtl/control_fsm_multiciclo_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, ALU-op codes,
// FSM state encodings and the opcode class held between DECODE and write-back.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_SLT   = 3'b010,
        ALU_AND   = 3'b101,
        ALU_OR    = 3'b110,
        ALU_FUNCT = 3'b111
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        CLS_R  = 2'd0,
        CLS_I  = 2'd1,
        CLS_LW = 2'd2,
        CLS_SW = 2'd3
    } op_class_t;

    // ALU operation for the immediate-arithmetic opcodes; ADD for anything else.
    function automatic alu_op_t imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_SLTI: return ALU_SLT;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_multiciclo_if.sv
// Control/status bundle between the multi-cycle control unit (master) and the
// datapath/memory side (slave).
interface control_fsm_multiciclo_if #(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal_op;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, retired
    );
endinterface

// File: rtl/control_fsm_multiciclo.sv
// Multi-cycle MIPS main control: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a
// memory-ready handshake, sticky illegal-opcode trap and retired-instruction counter.
module control_fsm_multiciclo
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3,
    parameter bit          MEM_HS  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    control_fsm_multiciclo_if.master bus
);

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    alu_op_t          imm_op_q, imm_op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;

    logic    rdy;
    logic    pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic    mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done;
    logic    [1:0] alu_src_b, pc_source;
    alu_op_t alu_op;

    // Without the handshake every memory access is treated as completing at once.
    assign rdy = !MEM_HS || bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        imm_op_d      = imm_op_q;
        illegal_d     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        instr_done    = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                if (rdy) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
                imm_op_d  = imm_alu_op(bus.opcode);
                case (bus.opcode)
                    OP_LW:  begin cls_d = CLS_LW; state_d = ST_MEM_ADDR; end
                    OP_SW:  begin cls_d = CLS_SW; state_d = ST_MEM_ADDR; end
                    OP_R:   begin cls_d = CLS_R;  state_d = ST_EXEC_R;   end
                    OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI:
                            begin cls_d = CLS_I;  state_d = ST_EXEC_I;   end
                    OP_BEQ: state_d = ST_BRANCH;
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (cls_q == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (rdy) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = rdy;
                if (rdy) state_d = ST_FETCH;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_op_q;
                state_d   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_q == CLS_R);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            cls_q     <= CLS_R;
            imm_op_q  <= ALU_ADD;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            imm_op_q <= imm_op_d;
            if (illegal_d) illegal_q <= 1'b1;
            if (instr_done) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.ir_write      = ir_write;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = ALUOP_W'(alu_op);
    assign bus.pc_source     = pc_source;
    assign bus.instr_done    = instr_done;
    assign bus.illegal_op    = illegal_q;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_control_fsm_multiciclo.sv
// Scoreboard bench for control_fsm_multiciclo: per-cycle expected control vectors
// are queued when an instruction is issued and compared as the DUT steps through it.
module tb_control_fsm_multiciclo;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_fsm_multiciclo_if #(.ALUOP_W(3), .CNT_W(16)) bus ();
    control_fsm_multiciclo_if #(.ALUOP_W(3), .CNT_W(2))  bus2 ();

    assign bus2.opcode    = bus.opcode;
    assign bus2.mem_ready = bus.mem_ready;

    control_fsm_multiciclo #(.ALUOP_W(3), .MEM_HS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    control_fsm_multiciclo #(.ALUOP_W(3), .MEM_HS(1'b1), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ret  = 0;
    int   wrap_pending = -1;
    int   wrap_exp [5] = '{1, 2, 3, 0, 1};

    ctl_t       exp_q [$];
    logic       rdy_q [$];
    logic [5:0] op_q  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.ir_write      = bus.ir_write;
        c.i_or_d        = bus.i_or_d;
        c.mem_read      = bus.mem_read;
        c.mem_write     = bus.mem_write;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_dst       = bus.reg_dst;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.alu_op        = bus.alu_op;
        c.pc_source     = bus.pc_source;
        c.instr_done    = bus.instr_done;
        c.illegal_op    = bus.illegal_op;
        return c;
    endfunction

    function automatic ctl_t c_fetch(input logic r);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b000;
        c.ir_write = r;    c.pc_write = r;
        return c;
    endfunction

    function automatic ctl_t c_alu(input logic a, input logic [1:0] b, input logic [2:0] op);
        ctl_t c = '0;
        c.alu_src_a = a; c.alu_src_b = b; c.alu_op = op;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic wr, input logic done);
        ctl_t c = '0;
        c.i_or_d = 1'b1; c.mem_read = !wr; c.mem_write = wr; c.instr_done = done;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic from_mem, input logic rd);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = from_mem; c.reg_dst = rd; c.instr_done = 1'b1;
        return c;
    endfunction

    task automatic push(input ctl_t e, input logic r, input logic [5:0] o);
        exp_q.push_back(e);
        rdy_q.push_back(r);
        op_q.push_back(o);
    endtask

    // One clock: drive this cycle's inputs just after the edge, compare at negedge.
    task automatic cycle();
        ctl_t e;
        @(posedge clk);
        #1;
        if (wrap_pending >= 0) begin
            check("retired_wrap", 32'(bus2.retired), 32'(wrap_exp[wrap_pending]));
            wrap_pending = -1;
        end
        bus.mem_ready = rdy_q.pop_front();
        bus.opcode    = op_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        check("ctl", 32'(observe()), 32'(e));
        check("retired", 32'(bus.retired), 32'(exp_ret));
        if (e.instr_done) exp_ret++;
    endtask

    task automatic issue(input logic [5:0] op, input int fetch_waits, input int mem_waits,
                         input int max_cycles);
        int n;
        logic [5:0] junk = 6'b111111;
        ctl_t t = '0;
        for (int i = 0; i < fetch_waits; i++) push(c_fetch(1'b0), 1'b0, junk);
        push(c_fetch(1'b1), 1'b1, junk);
        push(c_alu(1'b0, 2'b11, 3'b000), 1'b0, op);
        case (op)
            6'b100011: begin
                push(c_alu(1'b1, 2'b10, 3'b000), 1'b0, junk);
                for (int i = 0; i < mem_waits; i++) push(c_mem(1'b0, 1'b0), 1'b0, junk);
                push(c_mem(1'b0, 1'b0), 1'b1, junk);
                push(c_wb(1'b1, 1'b0), 1'b0, junk);
            end
            6'b101011: begin
                push(c_alu(1'b1, 2'b10, 3'b000), 1'b0, junk);
                for (int i = 0; i < mem_waits; i++) push(c_mem(1'b1, 1'b0), 1'b0, junk);
                push(c_mem(1'b1, 1'b1), 1'b1, junk);
            end
            6'b000000: begin
                push(c_alu(1'b1, 2'b00, 3'b111), 1'b0, junk);
                push(c_wb(1'b0, 1'b1), 1'b0, junk);
            end
            6'b001000, 6'b001100, 6'b001010, 6'b001101: begin
                push(c_alu(1'b1, 2'b10, (op == 6'b001000) ? 3'b000 :
                                        (op == 6'b001100) ? 3'b101 :
                                        (op == 6'b001010) ? 3'b010 : 3'b110), 1'b0, junk);
                push(c_wb(1'b0, 1'b0), 1'b0, junk);
            end
            6'b000100: begin
                t = c_alu(1'b1, 2'b00, 3'b001);
                t.pc_write_cond = 1'b1; t.pc_source = 2'b01; t.instr_done = 1'b1;
                push(t, 1'b1, junk);
            end
            default: begin
                t.illegal_op = 1'b1;
                for (int i = 0; i < 20; i++) push(t, (i % 2) == 0, 6'(i));
            end
        endcase
        n = exp_q.size();
        if (max_cycles < n) n = max_cycles;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset assert/hold/release; release lands mid-cycle so the
    // following edge is the first one seen with rst_n high.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_ctl", 32'(observe()), 32'h0);
        check("rst_retired", 32'(bus.retired), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_ctl_hold", 32'(observe()), 32'h0);
        check("rst_retired_hold", 32'(bus.retired), 32'h0);
        check("rst_retired_wrap", 32'(bus2.retired), 32'h0);
        rst_n = 1'b1;
        exp_q.delete();
        rdy_q.delete();
        op_q.delete();
        exp_ret = 0;
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b000000;
        do_reset();

        issue(6'b000000, 0, 0, 100);   // R-type
        issue(6'b100011, 0, 2, 100);   // LW, 2 wait cycles in MEM_RD
        issue(6'b101011, 1, 1, 100);   // SW, waits in FETCH and MEM_WR
        issue(6'b000100, 0, 0, 100);   // BEQ
        issue(6'b001101, 0, 0, 100);   // ORI
        issue(6'b001010, 0, 0, 100);   // SLTI
        issue(6'b001000, 0, 0, 100);   // ADDI
        issue(6'b001100, 2, 0, 100);   // ANDI, fetch stalls

        issue(6'b100011, 0, 3, 4);     // stop inside MEM_RD
        do_reset();

        for (int k = 0; k < 5; k++) begin
            issue(6'b000100, 0, 0, 100);
            wrap_pending = k;
        end

        issue(6'b111111, 0, 0, 100);   // illegal opcode -> TRAP
        check("illegal_sticky", 32'(bus.illegal_op), 32'h1);
        do_reset();
        check("illegal_cleared", 32'(bus.illegal_op), 32'h0);
        issue(6'b000100, 0, 0, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
